// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the synchronous instruction SRAM,
// and hands {pc, inst} to ID with a valid/allowin handshake and branch redirect.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_allowin,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        fs_to_ds_valid,
  output logic [31:0] fs_pc,
  output logic [31:0] fs_inst,
  output logic        fs_adef,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata
);

  logic        fs_valid;
  logic        fs_adef_r;
  logic        buf_valid;
  logic [31:0] inst_buf;
  logic [31:0] seq_pc;
  logic [31:0] nextpc;
  logic        fs_allowin;
  logic        fetch;
  logic        hold_capture;

  assign seq_pc     = fs_pc + 32'd4;
  assign nextpc     = br_taken ? br_target : seq_pc;
  assign fs_allowin = ~fs_valid | ds_allowin | br_taken;
  assign fetch      = ~reset & fs_allowin;

  // SRAM data lives for one cycle only; grab it on the first stalled cycle.
  assign hold_capture = fs_valid & ~ds_allowin & ~br_taken & ~buf_valid;

  assign inst_sram_en    = fetch & (nextpc[1:0] == 2'b00);
  assign inst_sram_we    = 4'h0;
  assign inst_sram_addr  = nextpc;
  assign inst_sram_wdata = 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      fs_valid  <= 1'b0;
      fs_pc     <= RESET_PC - 32'd4;
      fs_adef_r <= 1'b0;
      inst_buf  <= 32'h0;
      buf_valid <= 1'b0;
    end else if (fetch) begin
      fs_valid  <= 1'b1;
      fs_pc     <= nextpc;
      fs_adef_r <= (nextpc[1:0] != 2'b00);
      buf_valid <= 1'b0;
    end else if (hold_capture) begin
      inst_buf  <= inst_sram_rdata;
      buf_valid <= 1'b1;
    end
  end

  // A taken branch means the word in IF is wrong-path; it is dropped, no delay slot.
  assign fs_to_ds_valid = fs_valid & ~br_taken & ~reset;
  assign fs_adef        = fs_adef_r;
  assign fs_inst        = fs_adef_r ? 32'h0 : (buf_valid ? inst_buf : inst_sram_rdata);

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios followed by random traffic, all checked
// against a PC-level model of which instruction IF should be presenting.
module tb_if_stage;
  localparam logic [31:0] RESET_PC = 32'h1c000000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ds_allowin = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        fs_to_ds_valid;
  logic [31:0] fs_pc;
  logic [31:0] fs_inst;
  logic        fs_adef;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata = 32'h0;

  int checks = 0;
  int failures = 0;

  // Model: just "is IF holding something, and at which PC".
  logic        m_valid = 1'b0;
  logic [31:0] m_pc = RESET_PC - 32'd4;

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .ds_allowin(ds_allowin), .br_taken(br_taken),
    .br_target(br_target), .fs_to_ds_valid(fs_to_ds_valid), .fs_pc(fs_pc),
    .fs_inst(fs_inst), .fs_adef(fs_adef), .inst_sram_en(inst_sram_en),
    .inst_sram_we(inst_sram_we), .inst_sram_addr(inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata), .inst_sram_rdata(inst_sram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9e3779b1) ^ 32'h13579bdf;
  endfunction

  // Synchronous SRAM; output is garbage on any cycle without a request.
  always @(posedge clk)
    inst_sram_rdata <= inst_sram_en ? word(inst_sram_addr) : $urandom;

  always @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_pc    <= RESET_PC - 32'd4;
    end else if (br_taken) begin
      m_valid <= 1'b1;
      m_pc    <= br_target;
    end else if (!m_valid || ds_allowin) begin
      m_valid <= 1'b1;
      m_pc    <= m_pc + 32'd4;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then check against the model.
  task automatic cyc(input logic r, input logic ds, input logic br, input logic [31:0] tgt);
    logic [31:0] np;
    logic        exp_en;
    logic        exp_v;
    @(negedge clk);
    reset = r; ds_allowin = ds; br_taken = br; br_target = tgt;
    #1;
    np     = br ? tgt : m_pc + 32'd4;
    exp_en = !r && (!m_valid || ds || br) && (np[1:0] == 2'b00);
    exp_v  = m_valid && !br && !r;
    chk("sram_en", {31'h0, inst_sram_en}, {31'h0, exp_en});
    if (exp_en) chk("sram_addr", inst_sram_addr, np);
    chk("sram_we", {28'h0, inst_sram_we}, 32'h0);
    chk("valid", {31'h0, fs_to_ds_valid}, {31'h0, exp_v});
    if (exp_v) begin
      chk("pc", fs_pc, m_pc);
      chk("adef", {31'h0, fs_adef}, {31'h0, m_pc[1:0] != 2'b00});
      chk("inst", fs_inst, (m_pc[1:0] != 2'b00) ? 32'h0 : word(m_pc));
    end
  endtask

  initial begin
    logic [31:0] tgt;
    logic        r, ds, br;

    // Reset and start-up
    repeat (3) cyc(1, 0, 0, 32'h0);
    chk("reset_pc", fs_pc, RESET_PC - 32'd4);
    cyc(0, 1, 0, 32'h0);
    chk("first_addr", inst_sram_addr, RESET_PC);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 0, 32'h0);
      chk("run_pc", fs_pc, RESET_PC + 32'(4 * i));
      chk("run_inst", fs_inst, word(RESET_PC + 32'(4 * i)));
    end

    // Stall at 0x1c000008 with the SRAM output scrambled
    cyc(1, 1, 0, 32'h0);
    repeat (3) cyc(0, 1, 0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 32'h0);
      chk("stall_pc", fs_pc, 32'h1c000008);
      chk("stall_inst", fs_inst, word(32'h1c000008));
      chk("stall_en", {31'h0, inst_sram_en}, 32'h0);
    end
    cyc(0, 1, 0, 32'h0);
    chk("stall_rel_pc", fs_pc, 32'h1c000008);
    cyc(0, 1, 0, 32'h0);
    chk("after_stall_pc", fs_pc, 32'h1c00000c);

    // One-cycle redirect
    cyc(0, 1, 1, 32'h1c000100);
    chk("br_squash", {31'h0, fs_to_ds_valid}, 32'h0);
    cyc(0, 1, 0, 32'h0);
    chk("br_pc", fs_pc, 32'h1c000100);
    chk("br_inst", fs_inst, word(32'h1c000100));
    cyc(0, 1, 0, 32'h0);
    chk("br_next_pc", fs_pc, 32'h1c000104);

    // Redirect held across a stall
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 32'h1c000200);
      chk("br_hold_squash", {31'h0, fs_to_ds_valid}, 32'h0);
    end
    cyc(0, 1, 0, 32'h0);
    chk("br_hold_pc", fs_pc, 32'h1c000200);
    chk("br_hold_valid", {31'h0, fs_to_ds_valid}, 32'h1);
    cyc(0, 1, 0, 32'h0);
    chk("br_hold_next", fs_pc, 32'h1c000204);

    // Misaligned target
    cyc(0, 1, 1, 32'h1c000102);
    chk("adef_no_en", {31'h0, inst_sram_en}, 32'h0);
    cyc(0, 0, 0, 32'h0);
    chk("adef_flag", {31'h0, fs_adef}, 32'h1);
    chk("adef_inst", fs_inst, 32'h0);
    chk("adef_pc", fs_pc, 32'h1c000102);
    cyc(0, 0, 0, 32'h0);
    chk("adef_hold_inst", fs_inst, 32'h0);

    // PC wrap
    cyc(0, 1, 1, 32'hfffffffc);
    cyc(0, 1, 0, 32'h0);
    chk("wrap_top_pc", fs_pc, 32'hfffffffc);
    chk("wrap_addr", inst_sram_addr, 32'h0);
    cyc(0, 1, 0, 32'h0);
    chk("wrap_pc", fs_pc, 32'h0);

    // Random traffic, including resets mid-stall and mid-redirect
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(99) < 2);
      ds  = ($urandom_range(99) < 60);
      br  = ($urandom_range(99) < 15);
      tgt = $urandom;
      if ($urandom_range(3) != 0) tgt[1:0] = 2'b00;
      cyc(r, ds, br, tgt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage LoongArch pipeline. It sits directly upstream of ID. It owns the PC register and drives the synchronous instruction SRAM. It hands {pc, inst} to ID with a valid/allowin handshake, holds the fetched word while ID stalls, and redirects on ID's `br_taken`/`br_target`, squashing the wrong-path instruction.

## Interface

Parameters:
- `RESET_PC`, default `32'h1c000000`: address of the first fetched instruction.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: pipeline clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `ds_allowin` in 1: ID can accept an instruction this cycle.
- `br_taken` in 1: ID redirect request, already qualified by ID's valid.
- `br_target` in 32: redirect address.
- `fs_to_ds_valid` out 1: `fs_pc`/`fs_inst`/`fs_adef` are valid for ID.
- `fs_pc` out 32: PC of the instruction held in IF.
- `fs_inst` out 32: instruction word; 0 when `fs_adef`.
- `fs_adef` out 1: fetch address error, set when `fs_pc[1:0]!=0`.
- `inst_sram_en` out 1: SRAM read request.
- `inst_sram_we` out 4: tied to 0.
- `inst_sram_addr` out 32: request address (= `nextpc`).
- `inst_sram_wdata` out 32: tied to 0.
- `inst_sram_rdata` in 32: read data, valid exactly one cycle after an accepted request.

## Operation

- **State:**
  - `fs_valid` resets to 0.
  - `fs_pc` resets to `RESET_PC-4`.
  - `fs_adef_r` resets to 0.
  - `inst_buf` resets to 0.
  - `buf_valid` resets to 0.
- **Combinational terms:**
  - `seq_pc = fs_pc + 4`, 32-bit and wrapping.
  - `nextpc = br_taken ? br_target : seq_pc`.
  - `fs_allowin = ~fs_valid | ds_allowin | br_taken`.
  - `fetch = ~reset & fs_allowin`.
- **SRAM request:**
  - `inst_sram_en = fetch & (nextpc[1:0]==0)`.
  - `inst_sram_addr = nextpc`.
  - A misaligned `nextpc` issues no SRAM access.
- **Fetch update:** on `fetch`, `fs_valid<=1`, `fs_pc<=nextpc`, `fs_adef_r<=(nextpc[1:0]!=0)`, `buf_valid<=0`.
- **Hold buffer:** if `fs_valid & ~ds_allowin & ~br_taken & ~buf_valid`, then `inst_buf<=inst_sram_rdata` and `buf_valid<=1`. The SRAM output is never relied on past its one valid cycle.
- **Instruction output:** `fs_inst = fs_adef_r ? 0 : (buf_valid ? inst_buf : inst_sram_rdata)`.
- **Valid output:** `fs_to_ds_valid = fs_valid & ~br_taken`. The instruction in IF during a taken branch is the wrong path and is discarded; there is no delay slot.
- **Redirect:** `br_taken` has priority over `ds_allowin`. IF refetches `br_target` every cycle `br_taken` stays high, which covers ID holding a branch across a stall. Each refetch is idempotent. The cycle after `br_taken` falls, `fs_pc==br_target` and its data is present.
- **Reset:** reset at any time, including mid-stall or mid-redirect, forces all state to reset values. During reset, `inst_sram_en=0` and `fs_to_ds_valid=0`.

## Timing

- **Latency:** request in cycle N, and `fs_to_ds_valid` with the matching `fs_inst` in cycle N+1.
- **Throughput:** one instruction per cycle while `ds_allowin=1`.
- **Start-up:**
  - First cycle with `reset=0`: `inst_sram_addr=RESET_PC`, `en=1`.
  - Next cycle: `fs_pc=RESET_PC`, `fs_to_ds_valid=1`.
- **Handshake:** a transfer happens on an edge where `fs_to_ds_valid & ds_allowin`. `fs_pc`/`fs_inst` stay stable while `fs_to_ds_valid & ~ds_allowin`.
- **Stall:**
  - First stalled cycle: data comes from SRAM and is captured into the buffer.
  - Later stalled cycles: data comes from the buffer.
  - No SRAM request is issued while stalled.
- **Redirect:** `br_taken` in cycle N gives target data at `fs_to_ds_valid` in N+1, provided `br_taken` is low in N+1. The redirect penalty is one bubble.
- **Boundaries:**
  - `fs_pc=32'hfffffffc` sequential wraps to 0.
  - `br_taken` together with a stall: the stall is ignored and the buffer is cleared.
  - A misaligned target is delivered as `fs_adef=1`, `fs_inst=0`, with no SRAM access.

## Test plan

- Reset held 3 cycles, then released -> `fs_to_ds_valid=0` throughout reset. First request `addr=0x1c000000`. Next cycle `fs_pc=0x1c000000` and `fs_inst` equals SRAM word 0.
- Free-run 8 cycles with `ds_allowin=1` -> PCs `0x1c000000..0x1c00001c` in consecutive cycles, each paired with the correct SRAM word.
- `ds_allowin=0` for 4 cycles with `fs_pc=0x1c000008`, SRAM output scrambled after the first cycle -> `fs_pc`/`fs_inst` constant (buffered word), `inst_sram_en=0`. Release -> next PC `0x1c00000c`.
- `br_taken=1`, `br_target=0x1c000100` for one cycle -> `fs_to_ds_valid=0` that cycle. Next cycle `fs_pc=0x1c000100` with its word, then `0x1c000104`.
- `br_taken` held 3 cycles while `ds_allowin=0` -> `fs_to_ds_valid=0` for all 3. After release, the target is delivered once with no duplicate or skipped PC.
- `br_target=0x1c000102` -> no SRAM access. Next cycle `fs_adef=1`, `fs_inst=0`, `fs_pc=0x1c000102`.
